// File: rtl/pswd_pkg.sv
// Shared state encoding and parameter defaults for the password lockout checker.
package pswd_pkg;

  localparam int unsigned DefDigits     = 6;
  localparam int unsigned DefDigitW     = 4;
  localparam int unsigned DefIdW        = 3;
  localparam int unsigned DefAddrW      = 5;
  localparam int unsigned DefRomLat     = 2;
  localparam int unsigned DefMaxTries   = 3;
  localparam int unsigned DefWaitCyc    = 6;
  localparam int unsigned DefLockCyc    = 64;
  localparam int unsigned DefTimeoutCyc = 255;

  typedef enum logic [3:0] {
    StIdle,
    StEntry,
    StFetch,
    StRomWait,
    StCatch,
    StCompare,
    StPassed,
    StWait,
    StLocked
  } pswd_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pswd_lockout_check_if.sv
// Signal bundle between the password checker, the ID checker, the game controller and the ROM.
interface pswd_lockout_check_if
  import pswd_pkg::*;
#(
  parameter int unsigned DIGITS    = DefDigits,
  parameter int unsigned DIGIT_W   = DefDigitW,
  parameter int unsigned ID_W      = DefIdW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned MAX_TRIES = DefMaxTries
) ();

  localparam int unsigned FailW = $clog2(MAX_TRIES + 1);

  logic [DIGIT_W-1:0]        player_pswd;
  logic                      pswd_enter;
  logic [ID_W-1:0]           id_in;
  logic                      id_matched;
  logic                      is_guest_in;
  logic                      gc_logout;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DIGITS*DIGIT_W-1:0] rom_data;
  logic [ID_W-1:0]           internal_id;
  logic                      is_guest;
  logic                      loggedin;
  logic                      logout_id;
  logic                      locked;
  logic [FailW-1:0]          fail_cnt;

  modport master (
    output player_pswd, pswd_enter, id_in, id_matched, is_guest_in, gc_logout, rom_data,
    input  rom_addr, internal_id, is_guest, loggedin, logout_id, locked, fail_cnt
  );

  modport slave (
    input  player_pswd, pswd_enter, id_in, id_matched, is_guest_in, gc_logout, rom_data,
    output rom_addr, internal_id, is_guest, loggedin, logout_id, locked, fail_cnt
  );

endinterface

// File: rtl/pswd_cycle_timer.sv
// Loadable down-counter; done_o is high during the last cycle of a loaded interval.
module pswd_cycle_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A load of N therefore yields exactly N cycles before done_o.
  assign done_o = (cnt_q == Width'(1));

endmodule

// File: rtl/pswd_lockout_check.sv
// Password entry, ROM compare and lockout FSM. Define PSWD_TIMEOUT_EN to abandon an
// entry after TIMEOUT_CYC cycles without a digit strobe.
module pswd_lockout_check
  import pswd_pkg::*;
#(
  parameter int unsigned DIGITS      = DefDigits,
  parameter int unsigned DIGIT_W     = DefDigitW,
  parameter int unsigned ID_W        = DefIdW,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned ROM_LAT     = DefRomLat,
  parameter int unsigned MAX_TRIES   = DefMaxTries,
  parameter int unsigned WAIT_CYC    = DefWaitCyc,
  parameter int unsigned LOCK_CYC    = DefLockCyc,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic                clk,
  input  logic                rst,
  pswd_lockout_check_if.slave bus
);

  localparam int unsigned PswdW = DIGITS * DIGIT_W;
  localparam int unsigned FailW = $clog2(MAX_TRIES + 1);
  localparam int unsigned CntW  = $clog2(DIGITS + 1);
`ifdef PSWD_TIMEOUT_EN
  localparam int unsigned TimerMax = max_u(max_u(ROM_LAT, WAIT_CYC), max_u(LOCK_CYC, TIMEOUT_CYC));
`else
  localparam int unsigned TimerMax = max_u(max_u(ROM_LAT, WAIT_CYC), LOCK_CYC);
`endif
  localparam int unsigned TimerW = $clog2(TimerMax + 1);

  if (ROM_LAT < 1 || ROM_LAT > 7 || ADDR_W < ID_W || DIGITS < 2 || TIMEOUT_CYC < 1)
  begin : g_bad_param
    $error("pswd_lockout_check: illegal parameter combination");
  end

  pswd_state_e       state_q, state_d;
  logic [PswdW-1:0]  pswd_q, pswd_d;
  logic [PswdW-1:0]  rom_word_q, rom_word_d;
  logic [CntW-1:0]   digit_cnt_q, digit_cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ID_W-1:0]   internal_id_q, internal_id_d;
  logic              is_guest_q, is_guest_d;
  logic              loggedin_q, loggedin_d;
  logic              logout_id_q, logout_id_d;
  logic              locked_q, locked_d;
  logic [FailW-1:0]  fail_cnt_q, fail_cnt_d;
  logic              tmr_load;
  logic [TimerW-1:0] tmr_val;
  logic              tmr_done;

  pswd_cycle_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d       = state_q;
    pswd_d        = pswd_q;
    rom_word_d    = rom_word_q;
    digit_cnt_d   = digit_cnt_q;
    rom_addr_d    = rom_addr_q;
    internal_id_d = internal_id_q;
    is_guest_d    = is_guest_q;
    loggedin_d    = loggedin_q;
    logout_id_d   = 1'b0;
    locked_d      = locked_q;
    fail_cnt_d    = fail_cnt_q;
    tmr_load      = 1'b0;
    tmr_val       = '0;

    unique case (state_q)
      StIdle: begin
        internal_id_d = bus.id_in;
        is_guest_d    = bus.is_guest_in;
        if (bus.pswd_enter && bus.id_matched) begin
          state_d     = StEntry;
          pswd_d      = PswdW'(bus.player_pswd);
          digit_cnt_d = CntW'(1);
`ifdef PSWD_TIMEOUT_EN
          tmr_load    = 1'b1;
          tmr_val     = TimerW'(TIMEOUT_CYC);
`endif
        end
      end
      StEntry: begin
        // Shifting left leaves the first digit in the MSBs, matching the ROM layout.
        if (bus.pswd_enter) begin
          pswd_d      = {pswd_q[PswdW-DIGIT_W-1:0], bus.player_pswd};
          digit_cnt_d = digit_cnt_q + CntW'(1);
          if (digit_cnt_q == CntW'(DIGITS - 1)) begin
            state_d = StFetch;
          end
`ifdef PSWD_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TimerW'(TIMEOUT_CYC);
        end else if (tmr_done) begin
          state_d     = StIdle;
          pswd_d      = '0;
          digit_cnt_d = '0;
`endif
        end
      end
      StFetch: begin
        rom_addr_d = ADDR_W'(internal_id_q);
        state_d    = StRomWait;
        tmr_load   = 1'b1;
        tmr_val    = TimerW'(ROM_LAT);
      end
      StRomWait: begin
        if (tmr_done) begin
          state_d = StCatch;
        end
      end
      StCatch: begin
        rom_word_d = bus.rom_data;
        state_d    = StCompare;
      end
      StCompare: begin
        if (rom_word_q == pswd_q) begin
          fail_cnt_d = '0;
          loggedin_d = 1'b1;
          state_d    = StPassed;
        end else if (32'(fail_cnt_q) + 32'd1 < MAX_TRIES) begin
          fail_cnt_d  = fail_cnt_q + FailW'(1);
          logout_id_d = 1'b1;
          state_d     = StWait;
          tmr_load    = 1'b1;
          tmr_val     = TimerW'(WAIT_CYC);
        end else begin
          fail_cnt_d  = FailW'(MAX_TRIES);
          logout_id_d = 1'b1;
          locked_d    = 1'b1;
          state_d     = StLocked;
          tmr_load    = 1'b1;
          tmr_val     = TimerW'(LOCK_CYC);
        end
      end
      StPassed: begin
        if (bus.gc_logout) begin
          loggedin_d  = 1'b0;
          logout_id_d = 1'b1;
          state_d     = StWait;
          tmr_load    = 1'b1;
          tmr_val     = TimerW'(WAIT_CYC);
        end
      end
      StWait: begin
        if (tmr_done) begin
          state_d = StIdle;
        end
      end
      StLocked: begin
        if (tmr_done) begin
          locked_d   = 1'b0;
          fail_cnt_d = '0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      pswd_q        <= '0;
      rom_word_q    <= '0;
      digit_cnt_q   <= '0;
      rom_addr_q    <= '0;
      internal_id_q <= '0;
      is_guest_q    <= 1'b0;
      loggedin_q    <= 1'b0;
      logout_id_q   <= 1'b0;
      locked_q      <= 1'b0;
      fail_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pswd_q        <= pswd_d;
      rom_word_q    <= rom_word_d;
      digit_cnt_q   <= digit_cnt_d;
      rom_addr_q    <= rom_addr_d;
      internal_id_q <= internal_id_d;
      is_guest_q    <= is_guest_d;
      loggedin_q    <= loggedin_d;
      logout_id_q   <= logout_id_d;
      locked_q      <= locked_d;
      fail_cnt_q    <= fail_cnt_d;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.internal_id = internal_id_q;
  assign bus.is_guest    = is_guest_q;
  assign bus.loggedin    = loggedin_q;
  assign bus.logout_id   = logout_id_q;
  assign bus.locked      = locked_q;
  assign bus.fail_cnt    = fail_cnt_q;

endmodule

// File: tb/tb_pswd_lockout_check.sv
// Randomized bench for pswd_lockout_check against a transaction-level model of the login rules.
module tb_pswd_lockout_check;
  import pswd_pkg::*;

  localparam int unsigned Digits     = DefDigits;
  localparam int unsigned DigitW     = DefDigitW;
  localparam int unsigned PswdW      = Digits * DigitW;
  localparam int unsigned RomLat     = DefRomLat;
  localparam int unsigned MaxTries   = DefMaxTries;
  localparam int unsigned WaitCyc    = DefWaitCyc;
  localparam int unsigned LockCyc    = DefLockCyc;
  localparam int unsigned TimeoutCyc = DefTimeoutCyc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pswd_lockout_check_if bus ();

  pswd_lockout_check dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [PswdW-1:0] rom_mem [32];
  assign bus.rom_data = rom_mem[bus.rom_addr];

  int n_checks    = 0;
  int n_fail      = 0;
  int model_fails = 0;
  int exp_logouts = 0;
  int logout_seen = 0;

  always @(negedge clk) if (bus.logout_id === 1'b1) logout_seen++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
    check_eq({tag, "_internal_id"}, 32'(bus.internal_id), 0);
    check_eq({tag, "_is_guest"}, 32'(bus.is_guest), 0);
    check_eq({tag, "_loggedin"}, 32'(bus.loggedin), 0);
    check_eq({tag, "_logout_id"}, 32'(bus.logout_id), 0);
    check_eq({tag, "_locked"}, 32'(bus.locked), 0);
    check_eq({tag, "_fail_cnt"}, 32'(bus.fail_cnt), 0);
  endtask

  // Drives ndig strobes; returns #1 after the edge that samples the last one.
  task automatic enter_digits(input logic [PswdW-1:0] word, input int ndig);
    for (int i = 0; i < ndig; i++) begin
      if (i != 0) begin
        repeat ($urandom_range(0, 3)) begin
          bus.id_in       = 3'($urandom);
          bus.is_guest_in = 1'($urandom);
          step();
        end
      end
      bus.player_pswd = word[(Digits - 1 - i) * DigitW +: DigitW];
      bus.pswd_enter  = 1'b1;
      step();
      bus.pswd_enter  = 1'b0;
    end
  endtask

  function automatic int other_id(input int id);
    return (id + 1 + int'($urandom_range(0, 6))) % 8;
  endfunction

  // Called #1 after the edge that enters the wait interval.
  task automatic wait_to_idle(input int old_id);
    int nid;
    nid = other_id(old_id);
    bus.id_in = 3'(nid);
    step();
    check_eq("logout_pulse_end", 32'(bus.logout_id), 0);
    repeat (WaitCyc - 1) step();
    check_eq("wait_frozen_id", 32'(bus.internal_id), old_id);
    step();
    check_eq("wait_retrack_id", 32'(bus.internal_id), nid);
  endtask

  task automatic do_attempt(input int id, input logic [PswdW-1:0] word);
    bit match;
    bit guest;
    int nid;
    match = (word == rom_mem[id]);
    guest = 1'($urandom);
    bus.id_in       = 3'(id);
    bus.is_guest_in = guest;
    bus.id_matched  = 1'b1;
    step();
    check_eq("idle_track_id", 32'(bus.internal_id), id);
    check_eq("idle_track_guest", 32'(bus.is_guest), 32'(guest));
    enter_digits(word, Digits);
    check_eq("entry_frozen_id", 32'(bus.internal_id), id);
    check_eq("entry_frozen_guest", 32'(bus.is_guest), 32'(guest));
    step();
    check_eq("rom_addr", 32'(bus.rom_addr), id);
    repeat (RomLat + 1) step();
    check_eq("no_early_login", 32'(bus.loggedin), 0);
    check_eq("no_early_logout", 32'(bus.logout_id), 0);
    step();
    if (match) begin
      model_fails = 0;
      check_eq("login", 32'(bus.loggedin), 1);
      check_eq("login_fail_cnt", 32'(bus.fail_cnt), 0);
      check_eq("login_no_logout", 32'(bus.logout_id), 0);
      repeat ($urandom_range(1, 6)) begin
        bus.pswd_enter  = 1'($urandom);
        bus.player_pswd = 4'($urandom);
        step();
        check_eq("stay_logged_in", 32'(bus.loggedin), 1);
      end
      bus.pswd_enter = 1'b0;
      bus.gc_logout  = 1'b1;
      step();
      bus.gc_logout  = 1'b0;
      exp_logouts++;
      check_eq("gc_logout_loggedin", 32'(bus.loggedin), 0);
      check_eq("gc_logout_pulse", 32'(bus.logout_id), 1);
      wait_to_idle(id);
    end else if (model_fails + 1 < int'(MaxTries)) begin
      model_fails++;
      exp_logouts++;
      check_eq("wrong_pulse", 32'(bus.logout_id), 1);
      check_eq("wrong_fail_cnt", 32'(bus.fail_cnt), model_fails);
      check_eq("wrong_not_locked", 32'(bus.locked), 0);
      check_eq("wrong_not_logged", 32'(bus.loggedin), 0);
      wait_to_idle(id);
    end else begin
      model_fails = MaxTries;
      exp_logouts++;
      check_eq("lock_set", 32'(bus.locked), 1);
      check_eq("lock_fail_cnt", 32'(bus.fail_cnt), model_fails);
      check_eq("lock_pulse", 32'(bus.logout_id), 1);
      for (int c = 1; c < int'(LockCyc); c++) begin
        bus.pswd_enter  = 1'($urandom);
        bus.player_pswd = 4'($urandom);
        bus.gc_logout   = 1'($urandom);
        step();
        if (c == 1) check_eq("lock_pulse_end", 32'(bus.logout_id), 0);
      end
      bus.pswd_enter = 1'b0;
      bus.gc_logout  = 1'b0;
      check_eq("lock_held", 32'(bus.locked), 1);
      check_eq("lock_no_login", 32'(bus.loggedin), 0);
      check_eq("lock_fail_sat", 32'(bus.fail_cnt), MaxTries);
      step();
      model_fails = 0;
      check_eq("unlock", 32'(bus.locked), 0);
      check_eq("unlock_fail_cnt", 32'(bus.fail_cnt), 0);
      nid = other_id(id);
      bus.id_in = 3'(nid);
      step();
      check_eq("unlock_retrack_id", 32'(bus.internal_id), nid);
    end
  endtask

`ifdef PSWD_TIMEOUT_EN
  task automatic timeout_entry();
    int nid;
    bus.id_in      = 3'd5;
    bus.id_matched = 1'b1;
    step();
    enter_digits(rom_mem[5], 3);
    nid = other_id(5);
    bus.id_in = 3'(nid);
    repeat (TimeoutCyc) step();
    check_eq("timeout_frozen_id", 32'(bus.internal_id), 5);
    step();
    check_eq("timeout_retrack_id", 32'(bus.internal_id), nid);
    check_eq("timeout_fail_cnt", 32'(bus.fail_cnt), model_fails);
    check_eq("timeout_no_logout", 32'(bus.logout_id), 0);
  endtask
`endif

  task automatic reset_mid_romwait();
    bus.id_in      = 3'd3;
    bus.id_matched = 1'b1;
    step();
    enter_digits(rom_mem[3], Digits);
    step();
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("rst_romwait");
    model_fails = 0;
    step();
    #2;
    rst = 1'b1;
    do_attempt(3, rom_mem[3]);
  endtask

  initial begin
    logic [PswdW-1:0] mask;
    int id;
    for (int i = 0; i < 32; i++) rom_mem[i] = PswdW'($urandom);
    rom_mem[3] = 24'h123456;
    rst             = 1'b0;
    bus.player_pswd = '0;
    bus.pswd_enter  = 1'b0;
    bus.id_in       = '0;
    bus.id_matched  = 1'b0;
    bus.is_guest_in = 1'b0;
    bus.gc_logout   = 1'b0;
    #3;
    check_all_zero("por");
    step();
    step();
    #2;
    rst = 1'b1;

    do_attempt(3, 24'h123456);
    do_attempt(3, 24'h000000);
    do_attempt(3, 24'h000000);
    do_attempt(3, 24'h000000);

    // Strobe without a matched ID must leave the block tracking in IDLE.
    bus.id_matched  = 1'b0;
    bus.id_in       = 3'd2;
    bus.player_pswd = 4'h1;
    bus.pswd_enter  = 1'b1;
    step();
    bus.pswd_enter  = 1'b0;
    bus.id_in       = 3'd6;
    step();
    check_eq("unmatched_ignored", 32'(bus.internal_id), 6);

`ifdef PSWD_TIMEOUT_EN
    do_attempt(1, rom_mem[1] ^ 24'h000010);
    timeout_entry();
`endif

    do_attempt(4, rom_mem[4] ^ 24'h800000);
    reset_mid_romwait();

    for (int n = 0; n < 30; n++) begin
      id = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        do_attempt(id, rom_mem[id]);
      end else begin
        mask = PswdW'($urandom);
        if (mask == '0) mask = 24'h000001;
        do_attempt(id, rom_mem[id] ^ mask);
      end
    end

    step();
    check_eq("logout_pulse_total", 32'(logout_seen), 32'(exp_logouts));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
